// File: rtl/arb_mux_reg_pkg.sv
// Shared constants and helpers for the arbitrated, registered N:1 merge point.
package arb_mux_reg_pkg;

    // Arbitration modes
    localparam int unsigned ARB_FIXED = 0;  // lowest requesting index wins
    localparam int unsigned ARB_RR    = 1;  // round-robin starting at rr_ptr

    // Select-index width: clog2(n) with a floor of 1 bit
    function automatic int unsigned sel_w(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return int'($clog2(n));
    endfunction

endpackage

// File: rtl/arb_mux_reg_rr_arbiter.sv
// Combinational N-way arbiter: fixed-priority or round-robin, with a force-select override.
module rr_arbiter
    import arb_mux_reg_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned MODE = ARB_RR
) (
    input  logic [N-1:0]           req,
    input  logic [sel_w(N)-1:0]    rr_ptr,
    input  logic                   force_en,
    input  logic [sel_w(N)-1:0]    force_sel,
    output logic [N-1:0]           grant,
    output logic [sel_w(N)-1:0]    grant_idx
);

    localparam int unsigned SELW = sel_w(N);

    logic found;

    // Pick one requester; round-robin searches [rr_ptr, N-1] first, then wraps to [0, N-1]
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (force_en) begin
            // force_sel values >= N match no channel, so nothing is granted
            for (int unsigned i = 0; i < N; i++) begin
                if (force_sel == SELW'(i) && req[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end else begin
            if (MODE == ARB_RR) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (!found && req[i] && (i >= 32'(rr_ptr))) begin
                        found     = 1'b1;
                        grant[i]  = 1'b1;
                        grant_idx = SELW'(i);
                    end
                end
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && req[i]) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = SELW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/arb_mux_reg.sv
// Arbitrated N:1 merge point with a 1-cycle registered output and valid/ready handshakes.
module arb_mux_reg
    import arb_mux_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned N     = 4,
    parameter int unsigned MODE  = ARB_RR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*WIDTH-1:0]    in_data,
    input  logic [N-1:0]          in_valid,
    output logic [N-1:0]          in_ready,
    input  logic                  force_en,
    input  logic [sel_w(N)-1:0]   force_sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [sel_w(N)-1:0]   out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned SELW = sel_w(N);

    logic [N-1:0]     grant;
    logic [SELW-1:0]  grant_idx;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    logic [WIDTH-1:0] out_data_d,  out_data_q;
    logic [SELW-1:0]  out_sel_d,   out_sel_q;
    logic             out_valid_d, out_valid_q;
    logic [SELW-1:0]  rr_ptr_d,    rr_ptr_q;

    rr_arbiter #(
        .N    (N),
        .MODE (MODE)
    ) u_arb (
        .req       (in_valid),
        .rr_ptr    (rr_ptr_q),
        .force_en  (force_en),
        .force_sel (force_sel),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Handshake, AND-OR data select and next-state for the output register and rr pointer
    always_comb begin
        load     = ~out_valid_q | out_ready;
        xfer     = load & (|grant) & ~rst;
        in_ready = (load & ~rst) ? grant : '0;

        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end

        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = sel_data;
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            rr_ptr_d    = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + SELW'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and round-robin pointer; async reset drops any held word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
